// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer sharing one combinational ALU between core and debug.
// Optional NZCV flag register built when ALU_ARB_FLAGS_EN is defined.
module alu_share_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [2:0]   op0,
  input  logic [2:0]   op1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         s0,
  input  logic         s1,
  output logic         ack0,
  output logic         ack1,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_ctrl,
  input  logic [W-1:0] alu_out,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic [W-1:0] rsp_data,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [3:0]   flags,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_q;
  logic id_q;
  logic any_req;
  logic gnt1;
  logic grant;

  // Round-robin pick: on a tie the requester not granted last wins
  always_comb begin
    any_req = req0 | req1;
    gnt1    = req1 & (~req0 | ~last_q);
    grant   = (state == IDLE) & any_req;
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    ack0      = 1'b0;
    ack1      = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = EXEC;
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        ack0      = ~id_q;
        ack1      = id_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture at grant, result capture in EXEC, pointer update in DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= 3'd0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
    end else begin
      if (grant) begin
        alu_a    <= gnt1 ? a1 : a0;
        alu_b    <= gnt1 ? b1 : b0;
        alu_ctrl <= gnt1 ? op1 : op0;
        id_q     <= gnt1;
      end
      if (state == EXEC) begin
        rsp_data <= alu_out;
        rsp_id   <= id_q;
      end
      if (state == DONE) last_q <= id_q;
    end
  end

`ifdef ALU_ARB_FLAGS_EN
  logic       s_q;
  logic [3:0] flags_q;

  // NZCV: arithmetic codes load all four, logical codes keep C and V
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_q     <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      if (grant) s_q <= gnt1 ? s1 : s0;
      if ((state == EXEC) && s_q) begin
        flags_q[3] <= alu_n;
        flags_q[2] <= alu_z;
        if (alu_ctrl < 3'd3) begin
          flags_q[1] <= alu_c;
          flags_q[0] <= alu_v;
        end
      end
    end
  end

  assign flags = flags_q;
`else
  logic unused_flag_inputs;

  assign unused_flag_inputs =
    ^{s0, s1, alu_n, alu_z, alu_c, alu_v};
  assign flags = 4'b0000;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios then random traffic
// against a transaction-level reference model and an ALU model.
module tb_alu_share_arbiter;

  localparam int W = 32;
`ifdef ALU_ARB_FLAGS_EN
  localparam bit FL = 1'b1;
`else
  localparam bit FL = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         req0, req1;
  logic [2:0]   op0, op1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         s0, s1;
  logic         ack0, ack1;
  logic [W-1:0] alu_a, alu_b;
  logic [2:0]   alu_ctrl;
  logic [W-1:0] alu_out;
  logic         alu_n, alu_z, alu_c, alu_v;
  logic [W-1:0] rsp_data;
  logic         rsp_valid, rsp_id;
  logic [3:0]   flags;
  logic         busy;

  int errors = 0;
  int checks = 0;

  alu_share_arbiter #(.W(W)) dut (
    .clk(clk), .reset(rst),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .s0(s0), .s1(s1),
    .ack0(ack0), .ack1(ack1),
    .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_out(alu_out),
    .alu_n(alu_n), .alu_z(alu_z),
    .alu_c(alu_c), .alu_v(alu_v),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .flags(flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU behaviour: returns {N,Z,C,V,result}; logical ops drive C=V=1
  function automatic logic [35:0] alu_fn(
    input logic [2:0] op,
    input logic [31:0] a,
    input logic [31:0] b);
    logic [32:0] t;
    logic [31:0] r;
    logic c, v;
    c = 1'b1;
    v = 1'b1;
    t = '0;
    case (op)
      3'd0: begin
        t = {1'b0, a} + {1'b0, b};
        r = t[31:0];
        c = t[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        r = a - b;
        c = (a < b);
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: begin
        r = b - a;
        c = (b < a);
        v = (a[31] != b[31]) && (r[31] != b[31]);
      end
      3'd3: r = a & ~b;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = ~(a | b);
    endcase
    return {r[31], r == 32'd0, c, v, r};
  endfunction

  always_comb begin
    {alu_n, alu_z, alu_c, alu_v, alu_out} =
      alu_fn(alu_ctrl, alu_a, alu_b);
  end

  // Reference: age -1 = no op, 0 = granted (executing), 1 = responding
  int          m_age;
  logic        m_id, m_last, m_s, m_rid;
  logic [31:0] m_a, m_b, m_data;
  logic [2:0]  m_op;
  logic [3:0]  m_flags;

  task automatic model_reset();
    m_age   = -1;
    m_last  = 1'b1;
    m_id    = 1'b0;
    m_s     = 1'b0;
    m_rid   = 1'b0;
    m_a     = '0;
    m_b     = '0;
    m_op    = 3'd0;
    m_data  = '0;
    m_flags = 4'b0000;
  endtask

  task automatic model_edge();
    logic [35:0] res;
    if (rst) begin
      model_reset();
    end else if (m_age == 1) begin
      m_last = m_id;
      m_age  = -1;
    end else if (m_age == 0) begin
      res    = alu_fn(m_op, m_a, m_b);
      m_data = res[31:0];
      m_rid  = m_id;
      if (FL && m_s) begin
        if (m_op <= 3'd2) m_flags = res[35:32];
        else m_flags[3:2] = res[35:34];
      end
      m_age = 1;
    end else if (req0 || req1) begin
      m_id  = (req0 && req1) ? ~m_last : req1;
      m_a   = m_id ? a1 : a0;
      m_b   = m_id ? b1 : b0;
      m_op  = m_id ? op1 : op0;
      m_s   = m_id ? s1 : s0;
      m_age = 0;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("busy", busy, m_age >= 0);
    chk("rsp_valid", rsp_valid, m_age == 1);
    chk("ack0", ack0, (m_age == 1) && !m_id);
    chk("ack1", ack1, (m_age == 1) && m_id);
    chk("ack_excl", ack0 & ack1, 0);
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_id", rsp_id, m_rid);
    chk("flags", flags, m_flags);
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_ctrl", alu_ctrl, m_op);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_req(input logic id, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic s);
    if (id) begin
      req1 = 1'b1; op1 = op; a1 = a; b1 = b; s1 = s;
    end else begin
      req0 = 1'b1; op0 = op; a0 = a; b0 = b; s0 = s;
    end
  endtask

  task automatic run_op(input logic id, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic s,
                        output logic [31:0] data,
                        output logic [3:0] flg,
                        output logic rid,
                        output int lat);
    bit got;
    got  = 1'b0;
    lat  = 0;
    data = '0;
    flg  = '0;
    rid  = 1'b0;
    set_req(id, op, a, b, s);
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      if (id ? ack1 : ack0) begin
        got  = 1'b1;
        lat  = i + 1;
        data = rsp_data;
        flg  = flags;
        rid  = rsp_id;
      end
    end
    chk("op_timeout", got, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    step();
    rst = 1'b0;
  endtask

  logic [31:0] d;
  logic [3:0]  f;
  logic        rid;
  int          lat;
  logic        order[$];
  int          gap;
  bit          seen_busy;
  bit          got;

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    op0 = '0; op1 = '0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    s0 = 1'b0; s1 = 1'b0;
    model_reset();
    step();
    step();
    chk("reset_busy", busy, 0);
    chk("reset_flags", flags, 0);
    rst = 1'b0;
    step();

    // single request, overflow add
    run_op(1'b0, 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, d, f, rid, lat);
    chk("single_lat", lat, 2);
    chk("single_data", d, 32'h8000_0000);
    chk("single_id", rid, 0);
    chk("single_flags", f, FL ? 4'b1001 : 4'b0000);

    // logical op keeps C/V
    run_op(1'b0, 3'd1, 32'd0, 32'd1, 1'b1, d, f, rid, lat);
    chk("sub_data", d, 32'hFFFF_FFFF);
    chk("sub_flags", f, FL ? 4'b1010 : 4'b0000);
    run_op(1'b1, 3'd4, 32'd0, 32'd0, 1'b1, d, f, rid, lat);
    chk("and_data", d, 0);
    chk("and_id", rid, 1);
    chk("and_flags", f, FL ? 4'b0110 : 4'b0000);

    // no flag update when s=0
    run_op(1'b0, 3'd1, 32'd0, 32'd1, 1'b1, d, f, rid, lat);
    run_op(1'b1, 3'd1, 32'd5, 32'd5, 1'b0, d, f, rid, lat);
    chk("nos_data", d, 0);
    chk("nos_flags", f, FL ? 4'b1010 : 4'b0000);

    // continuous contention after reset
    pulse_reset();
    set_req(1'b0, 3'd5, 32'h1234_0000, 32'h0000_5678, 1'b1);
    set_req(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    gap = 0;
    seen_busy = 1'b0;
    for (int i = 0; i < 40 && order.size() < 4; i++) begin
      step();
      if (ack0) order.push_back(1'b0);
      if (ack1) order.push_back(1'b1);
      if (!busy) gap++;
      else begin
        if (seen_busy && gap != 0) chk("busy_gap", gap, 1);
        gap = 0;
        seen_busy = 1'b1;
      end
    end
    chk("cont_count", order.size(), 4);
    while (order.size() < 4) order.push_back(1'bx);
    chk("cont_0", order[0], 0);
    chk("cont_1", order[1], 1);
    chk("cont_2", order[2], 0);
    chk("cont_3", order[3], 1);
    req0 = 1'b0;
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // reset during EXEC, then a tie goes to requester 0
    set_req(1'b1, 3'd6, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b1);
    step();
    chk("rst_pre_busy", busy, 1);
    req1 = 1'b0;
    pulse_reset();
    chk("rst_busy", busy, 0);
    chk("rst_alu_a", alu_a, 0);
    set_req(1'b0, 3'd5, 32'd1, 32'd2, 1'b0);
    set_req(1'b1, 3'd5, 32'd4, 32'd8, 1'b0);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      if (ack0 || ack1) begin
        got = 1'b1;
        chk("rst_tie_ack0", ack0, 1);
        chk("rst_tie_data", rsp_data, 32'd3);
      end
    end
    chk("rst_tie_timeout", got, 1);
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();

    // random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      if (!req0) begin
        if ($urandom_range(0, 2) == 0)
          set_req(1'b0, 3'($urandom_range(0, 7)), rnd32(),
                  rnd32(), 1'($urandom_range(0, 1)));
      end else if (ack0) begin
        if ($urandom_range(0, 1) == 0) req0 = 1'b0;
        else set_req(1'b0, 3'($urandom_range(0, 7)), rnd32(),
                     rnd32(), 1'($urandom_range(0, 1)));
      end else if (m_age == 0 && !m_id) begin
        if ($urandom_range(0, 5) == 0) req0 = 1'b0;
      end
      if (!req1) begin
        if ($urandom_range(0, 2) == 0)
          set_req(1'b1, 3'($urandom_range(0, 7)), rnd32(),
                  rnd32(), 1'($urandom_range(0, 1)));
      end else if (ack1) begin
        if ($urandom_range(0, 1) == 0) req1 = 1'b0;
        else set_req(1'b1, 3'($urandom_range(0, 7)), rnd32(),
                     rnd32(), 1'($urandom_range(0, 1)));
      end else if (m_age == 0 && m_id) begin
        if ($urandom_range(0, 5) == 0) req1 = 1'b0;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
